stall_ctrl: RTL and testbench
=============================

// Module: stall_ctrl
// PURPOSE
//  Pipeline stall/sequencing controller for the 5-stage CPU. Detects load-use
//  hazards that forwarding cannot cover and sequences the multi-cycle
//  iterative divider in EX. Drives the shared stall bus consumed by PC/IF/ID/EX/MEM/WB.
//  Also keeps a saturating stall-cycle counter and a sticky divider-timeout flag.
// PARAMETERS
//  STALL_W      6   stall bus width; bit k=1 holds pipeline reg k (0 PC,1 IF,2 ID,3 EX,4 MEM,5 WB)
//  DIV_TIMEOUT  40  max DIV_BUSY cycles before forced release
//  CNT_W        32  width of stall_cnt
// PORTS
//  clk             in   1        clock, rising edge
//  rst             in   1        reset, asynchronous, active-high
//  ex_is_load      in   1        EX holds a load (lw)
//  ex_we           in   1        EX instruction writes regfile
//  ex_waddr        in   5        EX destination register
//  id_rs           in   5        ID source reg rs
//  id_rt           in   5        ID source reg rt
//  id_uses_rs      in   1        ID instruction reads rs
//  id_uses_rt      in   1        ID instruction reads rt
//  ex_is_div       in   1        EX holds div/divu
//  div_ready       in   1        divider result valid (single-cycle pulse)
//  stall           out  STALL_W  stall bus (1 = Stop)
//  div_start       out  1        one-cycle divider start pulse
//  busy            out  1        FSM not in RUN
//  div_timeout_err out  1        sticky: divider timed out
//  stall_cnt       out  CNT_W    saturating count of cycles with stall!=0
// BEHAVIOUR
//  Reset (async, immediate): state=RUN, busy_cnt=0, stall=0, div_start=0,
//   busy=0, div_timeout_err=0, stall_cnt=0. Reset mid-DIV_BUSY aborts with no pulse.
//  Bubble rule: stage k+1 gets a bubble when stall[k]=1 and stall[k+1]=0.
//  load_use = ex_is_load & ex_we & ex_waddr!=0 &
//   ((id_uses_rs & id_rs==ex_waddr) | (id_uses_rt & id_rt==ex_waddr)); combinational.
//  FSM states: RUN, DIV_BUSY.
//  RUN:
//   - ex_is_div=1 -> div_start=1 this cycle, stall=6'b001111, next DIV_BUSY, busy_cnt<=0.
//     Div has priority over simultaneous load_use.
//   - else load_use=1 -> stall=6'b000111 (one EX bubble), stay RUN; no
//     registered state, so re-detection ends naturally once bubble is in EX.
//   - else stall=0.
//  DIV_BUSY: busy=1, div_start=0.
//   - div_ready=1 -> stall=0 this cycle (div result leaves EX), next RUN.
//   - else busy_cnt==DIV_TIMEOUT-1 -> stall=0, div_timeout_err<=1, next RUN.
//   - else stall=6'b001111, busy_cnt<=busy_cnt+1.
//   - div_ready in the same cycle as timeout: ready wins, no error.
//  div_ready outside DIV_BUSY is ignored.
//  Outputs stall, div_start, busy: combinational from state + inputs.
//  stall_cnt: +1 each cycle stall!=0; holds at all-ones (no wrap).
//  div_timeout_err: cleared only by rst.
//  Bits stall[5:4] are always 0 from this block.
// TESTING
//  1 ex_is_load=1,ex_we=1,ex_waddr=5,id_rs=5,id_uses_rs=1 -> stall=6'b000111 same cycle,
//    stall_cnt 0->1; next cycle ex_is_load=0 -> stall=0.
//  2 Same as 1 with ex_waddr=0, or id_uses_rs=0 -> stall=0, stall_cnt unchanged.
//  3 RUN, ex_is_div=1 -> div_start=1 for exactly 1 cycle, stall=6'b001111;
//    div_ready on 33rd DIV_BUSY cycle -> stall=0 that cycle, busy=0 next, stall_cnt=33.
//  4 DIV_TIMEOUT=40, never div_ready -> stall=0 on 40th DIV_BUSY cycle,
//    div_timeout_err=1 and stays 1 through later divides until rst.
//  5 ex_is_div=1 and load_use=1 same cycle -> stall=6'b001111, div_start=1, enter DIV_BUSY.
//  6 rst asserted 10 cycles into DIV_BUSY, off clock edge -> stall=0, busy=0,
//    stall_cnt=0 immediately; after release ex_is_div=0 -> stays RUN.

Source files
------------

// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl
// Pipeline stall/sequencing controller for the 5-stage CPU. It detects load-use
// hazards that forwarding cannot cover and sequences the multi-cycle iterative
// divider in EX. It also keeps a saturating stall-cycle counter and a sticky
// divider-timeout flag.
//
// State table
//   state    | meaning
//   RUN      | normal flow; a divide entering EX, or a load-use hazard, raises stall
//   DIV_BUSY | waiting for the divider to report ready, or for the timeout
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   asynchronous, active-high reset
//   ex_is_load      in   EX holds a load
//   ex_we           in   EX instruction writes the regfile
//   ex_waddr        in   EX destination register
//   id_rs, id_rt    in   ID source registers
//   id_uses_rs/rt   in   ID instruction reads rs / rt
//   ex_is_div       in   EX holds div/divu
//   div_ready       in   divider result valid (single-cycle pulse)
//   stall           out  stall bus, bit k holds pipeline reg k (0 PC .. 5 WB)
//   div_start       out  one-cycle divider start pulse
//   busy            out  FSM is not in RUN
//   div_timeout_err out  sticky divider-timeout flag
//   stall_cnt       out  saturating count of cycles with stall != 0
// -----------------------------------------------------------------------------
module stall_ctrl #(
    parameter int STALL_W     = 6,
    parameter int DIV_TIMEOUT = 40,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_is_load,
    input  logic               ex_we,
    input  logic [4:0]         ex_waddr,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic               ex_is_div,
    input  logic               div_ready,
    output logic [STALL_W-1:0] stall,
    output logic               div_start,
    output logic               busy,
    output logic               div_timeout_err,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int BC_W = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DIV_TIMEOUT - 1);

    // Load-use holds PC/IF/ID so a bubble enters EX; a divide also holds EX,
    // which bubbles MEM. MEM and WB are never held by this block.
    localparam logic [STALL_W-1:0] HOLD_LOAD = STALL_W'(4'b0111);
    localparam logic [STALL_W-1:0] HOLD_DIV  = STALL_W'(4'b1111);

    typedef enum logic {
        RUN      = 1'b0,
        DIV_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [BC_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_use;

    // Purely combinational: once the bubble reaches EX the match disappears,
    // so no state is needed to end the stall.
    assign load_use = ex_is_load & ex_we & (ex_waddr != 5'd0) &
                      ((id_uses_rs & (id_rs == ex_waddr)) |
                       (id_uses_rt & (id_rt == ex_waddr)));

    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        err_d      = err_q;
        stall      = '0;
        div_start  = 1'b0;
        busy       = 1'b0;
        case (state_q)
            RUN: begin
                // A divide wins over a simultaneous load-use hazard: its
                // stall pattern already covers PC/IF/ID.
                if (ex_is_div) begin
                    div_start  = 1'b1;
                    stall      = HOLD_DIV;
                    state_d    = DIV_BUSY;
                    busy_cnt_d = '0;
                end else if (load_use) begin
                    stall = HOLD_LOAD;
                end
            end
            DIV_BUSY: begin
                busy = 1'b1;
                // Ready on the timeout cycle still counts as a good result.
                if (div_ready) begin
                    state_d = RUN;
                end else if (busy_cnt_q == BC_LAST) begin
                    state_d = RUN;
                    err_d   = 1'b1;
                end else begin
                    stall      = HOLD_DIV;
                    busy_cnt_d = busy_cnt_q + BC_W'(1);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((|stall) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            busy_cnt_q <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign div_timeout_err = err_q;
    assign stall_cnt       = cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stall_ctrl
// Directed bench for stall_ctrl. A behavioural model tracks whether a divide
// is outstanding and how many wait cycles have elapsed, and the compare
// process checks every DUT output against it on each falling edge. Literal
// expectations at key points pin the model itself. stall_cnt is built narrow
// so that saturation is reached within a short run.
// -----------------------------------------------------------------------------
module tb_stall_ctrl;

    localparam int STALL_W     = 6;
    localparam int DIV_TIMEOUT = 40;
    localparam int CNT_W       = 6;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst;
    logic               ex_is_load;
    logic               ex_we;
    logic [4:0]         ex_waddr;
    logic [4:0]         id_rs;
    logic [4:0]         id_rt;
    logic               id_uses_rs;
    logic               id_uses_rt;
    logic               ex_is_div;
    logic               div_ready;
    logic [STALL_W-1:0] stall;
    logic               div_start;
    logic               busy;
    logic               div_timeout_err;
    logic [CNT_W-1:0]   stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    stall_ctrl #(
        .STALL_W    (STALL_W),
        .DIV_TIMEOUT(DIV_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_is_load     (ex_is_load),
        .ex_we          (ex_we),
        .ex_waddr       (ex_waddr),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .ex_is_div      (ex_is_div),
        .div_ready      (div_ready),
        .stall          (stall),
        .div_start      (div_start),
        .busy           (busy),
        .div_timeout_err(div_timeout_err),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_div     = 1'b0;   // a divide is outstanding
    int m_elapsed = 0;      // wait cycles already spent on it
    bit m_err     = 1'b0;
    int m_cnt     = 0;

    function automatic bit m_hazard();
        if (!(ex_is_load && ex_we) || ex_waddr == 5'd0) return 1'b0;
        return (id_uses_rs && id_rs == ex_waddr) || (id_uses_rt && id_rt == ex_waddr);
    endfunction

    function automatic logic [5:0] m_stall();
        if (!m_div) begin
            if (ex_is_div) return 6'b001111;
            if (m_hazard()) return 6'b000111;
            return 6'b000000;
        end
        if (div_ready) return 6'b000000;
        if (m_elapsed + 1 == DIV_TIMEOUT) return 6'b000000;
        return 6'b001111;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_div     <= 1'b0;
            m_elapsed <= 0;
            m_err     <= 1'b0;
            m_cnt     <= 0;
        end else begin
            if (m_stall() != 6'b0 && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
            if (!m_div) begin
                if (ex_is_div) begin
                    m_div     <= 1'b1;
                    m_elapsed <= 0;
                end
            end else if (div_ready) begin
                m_div <= 1'b0;
            end else if (m_elapsed + 1 == DIV_TIMEOUT) begin
                m_div <= 1'b0;
                m_err <= 1'b1;
            end else begin
                m_elapsed <= m_elapsed + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_stall", stall, m_stall());
        check("cyc_div_start", div_start, (!m_div && ex_is_div) ? 1 : 0);
        check("cyc_busy", busy, m_div ? 1 : 0);
        check("cyc_timeout_err", div_timeout_err, m_err ? 1 : 0);
        check("cyc_stall_cnt", stall_cnt, m_cnt);
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_is_load = 1'b0; ex_we = 1'b0; ex_waddr = 5'd0;
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_is_div = 1'b0; div_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        #1;
        check("reset_stall", stall, 0);
        check("reset_busy", busy, 0);
        check("reset_cnt", stall_cnt, 0);
        check("reset_err", div_timeout_err, 0);
        step(1);

        // load-use through rs
        ex_is_load = 1'b1; ex_we = 1'b1; ex_waddr = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        #1 check("t1_stall", stall, 6'b000111);
        step(1);
        check("t1_cnt", stall_cnt, 1);
        ex_is_load = 1'b0;
        #1 check("t1_release", stall, 0);
        step(1);

        // no hazard: r0 destination, then rs not used
        ex_is_load = 1'b1; ex_waddr = 5'd0; id_rs = 5'd0;
        #1 check("t2_r0", stall, 0);
        step(1);
        ex_waddr = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b0;
        #1 check("t2_no_use", stall, 0);
        step(1);
        check("t2_cnt", stall_cnt, 1);
        // hazard through rt, then ex_we low kills it
        id_uses_rt = 1'b1; id_rt = 5'd5;
        #1 check("t2_rt", stall, 6'b000111);
        step(1);
        ex_we = 1'b0;
        #1 check("t2_no_we", stall, 0);
        step(1);
        clear_inputs();
        check("t2_cnt_end", stall_cnt, 2);
        // div_ready outside a divide is ignored
        div_ready = 1'b1;
        step(1);
        div_ready = 1'b0;
        check("stray_ready_busy", busy, 0);
        step(1);

        // divide completing on the 33rd wait cycle
        pulse_reset();
        ex_is_div = 1'b1;
        #1 check("t3_start", div_start, 1);
        check("t3_stall", stall, 6'b001111);
        step(1);
        check("t3_start_once", div_start, 0);
        check("t3_busy", busy, 1);
        step(31);
        step(1);
        div_ready = 1'b1;
        #1 check("t3_ready_stall", stall, 0);
        step(1);
        div_ready = 1'b0; ex_is_div = 1'b0;
        check("t3_busy_after", busy, 0);
        check("t3_cnt", stall_cnt, 33);
        step(1);

        // ready on the 40th wait cycle: ready wins, no error; counter saturates
        ex_is_div = 1'b1;
        step(1);
        step(39);
        div_ready = 1'b1;
        #1 check("tie_stall", stall, 0);
        step(1);
        div_ready = 1'b0; ex_is_div = 1'b0;
        check("tie_err", div_timeout_err, 0);
        check("tie_busy", busy, 0);
        check("sat_cnt", stall_cnt, CNT_MAX);
        step(1);

        // timeout on the 40th wait cycle
        ex_is_div = 1'b1;
        step(1);
        step(39);
        #1 check("t4_stall", stall, 0);
        check("t4_busy", busy, 1);
        step(1);
        ex_is_div = 1'b0;
        check("t4_err", div_timeout_err, 1);
        check("t4_busy_after", busy, 0);
        step(1);
        ex_is_div = 1'b1;
        step(3);
        div_ready = 1'b1;
        step(1);
        div_ready = 1'b0; ex_is_div = 1'b0;
        check("t4_err_sticky", div_timeout_err, 1);
        step(1);

        // divide and load-use together, then reset mid-divide
        pulse_reset();
        check("t5_err_cleared", div_timeout_err, 0);
        ex_is_load = 1'b1; ex_we = 1'b1; ex_waddr = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
        ex_is_div = 1'b1;
        #1 check("t5_stall", stall, 6'b001111);
        check("t5_start", div_start, 1);
        step(1);
        ex_is_load = 1'b0; ex_we = 1'b0; id_uses_rt = 1'b0;
        check("t5_busy", busy, 1);
        step(9);
        #2;
        ex_is_div = 1'b0;
        rst = 1'b1;
        #1 check("t6_stall", stall, 0);
        check("t6_busy", busy, 0);
        check("t6_cnt", stall_cnt, 0);
        check("t6_start", div_start, 0);
        step(1);
        rst = 1'b0;
        step(3);
        check("t6_stays_run", busy, 0);
        check("t6_cnt_after", stall_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: stimulus did not complete, time %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
